// File: rtl/dmem_copy_engine_if.sv
// Bus bundle between the DMEM copy engine and its controller / data memory.
// The checksum signal exists only when DMEM_COPY_CHECKSUM_EN is defined.
interface dmem_copy_engine_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_a;
    logic             mem_we;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    // Engine side: consumes the request and read data, drives status and the memory port.
    modport master (
        input  start, src_addr, dst_addr, len, mem_rd,
        output busy, done, err, mem_a, mem_we, mem_wd
`ifdef DMEM_COPY_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rd,
        input  busy, done, err, mem_a, mem_we, mem_wd
`ifdef DMEM_COPY_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-by-word block copy engine driving the single-cycle MIPS data-memory port.
// Optional running sum of copied words: define DMEM_COPY_CHECKSUM_EN.
module dmem_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_copy_engine_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_ptr, dst_ptr;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      data_buf;
    logic [31:0]      last_a;
    logic             err_q;
    logic             accept, reject;
    logic             misaligned;
    logic [31:0]      mem_a_c;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [31:0]      checksum_q;
`endif

    assign misaligned = (bus.src_addr[1:0] != 2'b00) || (bus.dst_addr[1:0] != 2'b00);

    // NOTE: the state register is reset asynchronously; bus outputs decoded from it
    // (busy, mem_we, done) therefore drop the moment rst_n falls, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable written here gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = (bus.len == '0) ? S_DONE : S_READ;
                    end
                end
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address mux; outside READ/WRITE the port keeps presenting the last address used.
    always_comb begin
        mem_a_c = last_a;
        case (state_q)
            S_READ:  mem_a_c = src_ptr;
            S_WRITE: mem_a_c = dst_ptr;
            default: mem_a_c = last_a;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // below sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt_q    <= '0;
            data_buf <= '0;
            last_a   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                src_ptr <= bus.src_addr;
                dst_ptr <= bus.dst_addr;
                cnt_q   <= bus.len;
            end
            if (state_q == S_READ) begin
                data_buf <= bus.mem_rd;
                last_a   <= src_ptr;
            end
            if (state_q == S_WRITE) begin
                src_ptr <= src_ptr + 32'd4;
                dst_ptr <= dst_ptr + 32'd4;
                cnt_q   <= cnt_q - LEN_W'(1);
                last_a  <= dst_ptr;
            end
        end
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  checksum_q <= '0;
        else if (accept)             checksum_q <= '0;
        else if (state_q == S_WRITE) checksum_q <= checksum_q + data_buf;
    end
    assign bus.checksum = checksum_q;
`endif

    assign bus.busy   = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.err    = err_q;
    assign bus.mem_we = (state_q == S_WRITE);
    assign bus.mem_a  = mem_a_c;
    // data_buf only changes on READ edges, so it already holds the last written word elsewhere.
    assign bus.mem_wd = data_buf;
endmodule
